// File: rtl/pcm_mclk_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_mclk_sync_pkg
//  Description : Shared types, capture-edge codes and sizing helper for
//                pcm_mclk_sync_mc.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcm_mclk_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int CAP_RISE = 0;
  localparam int CAP_FALL = 1;

  // One spare bit so the counter can pass MCLK_PER_FS+TOL and still saturate.
  function automatic int frame_cnt_width(input int per, input int tol);
    return $clog2(per + tol + 1) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcm_mclk_sync_mc_sync_ff_chain.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff_chain
//  Description : Single-bit multi-flop synchroniser, synchronous active-low
//                reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pcm_mclk_sync_mc.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_mclk_sync_mc
//  Description : Resynchronises an async word clock and N-channel PCM bus into
//                the MCLK domain; optional frame-period monitor enabled by
//                macro PCM_MCLK_SYNC_MON_EN (lock, error pulse, mute).
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_mclk_sync_mc
  import pcm_mclk_sync_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CH_NUM       = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int CAPTURE_EDGE = 0,
  parameter int MCLK_PER_FS  = 512,
  parameter int TOL          = 2,
  parameter int LOCK_FRAMES  = 4
) (
  input  logic                         MCLK_I,
  input  logic                         ARESETN_I,
  input  logic                         WCLK_I,
  input  logic [CH_NUM*DATA_WIDTH-1:0] PCM_I,
  output logic                         WCLK_O,
  output logic [CH_NUM*DATA_WIDTH-1:0] PCM_O,
  output logic                         VALID_O,
  output logic                         LOCK_O,
  output logic                         ERR_O
);

  localparam int PCM_W      = CH_NUM * DATA_WIDTH;
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

  logic             wclk_sync;
  logic             prev_q;
  logic [ARM_W-1:0] arm_q;
  logic             armed;
  logic             edge_raw;
  logic             cap_edge;
  logic             valid_q;
  logic [PCM_W-1:0] pcm_q;
  logic             lock_q;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_wclk_sync (
    .clk_i  (MCLK_I),
    .rst_ni (ARESETN_I),
    .d_i    (WCLK_I),
    .q_o    (wclk_sync)
  );

  // Arming hides the chain filling up after reset (e.g. WCLK_I already high).
  always_ff @(posedge MCLK_I) begin
    if (!ARESETN_I) begin
      prev_q  <= 1'b0;
      arm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= wclk_sync;
      if (!armed) begin
        arm_q <= arm_q + 1'b1;
      end
      valid_q <= cap_edge;
    end
  end

  assign armed = (arm_q == ARM_W'(ARM_CYCLES));

  if (CAPTURE_EDGE == CAP_FALL) begin : g_cap_fall
    assign edge_raw = ~wclk_sync & prev_q;
  end else begin : g_cap_rise
    assign edge_raw = wclk_sync & ~prev_q;
  end

  assign cap_edge = armed & edge_raw;

`ifdef PCM_MCLK_SYNC_MON_EN
  localparam int                CNT_W     = frame_cnt_width(MCLK_PER_FS, TOL);
  localparam logic [CNT_W-1:0]  CNT_LO    = CNT_W'(MCLK_PER_FS - TOL);
  localparam logic [CNT_W-1:0]  CNT_HI    = CNT_W'(MCLK_PER_FS + TOL);
  localparam int                GOOD_W    = $clog2(LOCK_FRAMES + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

  mon_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [GOOD_W-1:0] good_q;
  logic              err_q;
  logic              in_tol;
  logic              timeout;

  assign in_tol  = (cnt_q >= CNT_LO) && (cnt_q <= CNT_HI);
  assign timeout = (cnt_q > CNT_HI);

  // While unlocked pcm_q is held at zero, so capture only happens when locked
  // or on the edge that achieves lock.
  always_ff @(posedge MCLK_I) begin
    if (!ARESETN_I) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      good_q  <= '0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
      pcm_q   <= '0;
    end else begin
      err_q <= 1'b0;
      if (cap_edge) begin
        cnt_q <= CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (cap_edge && lock_q) begin
        pcm_q <= PCM_I;
      end
      case (state_q)
        IDLE: begin
          if (cap_edge) begin
            state_q <= ACQ;
            good_q  <= '0;
          end
        end
        ACQ: begin
          if (cap_edge) begin
            if (!in_tol) begin
              good_q <= '0;
              err_q  <= 1'b1;
            end else if (good_q == GOOD_LAST) begin
              state_q <= LOCKED;
              lock_q  <= 1'b1;
              pcm_q   <= PCM_I;
            end else begin
              good_q <= good_q + 1'b1;
            end
          end else if (timeout) begin
            state_q <= IDLE;
            good_q  <= '0;
            err_q   <= 1'b1;
          end
        end
        LOCKED: begin
          // A late edge coinciding with timeout is judged as a bad edge.
          if ((cap_edge && !in_tol) || (!cap_edge && timeout)) begin
            state_q <= cap_edge ? ACQ : IDLE;
            good_q  <= '0;
            err_q   <= 1'b1;
            lock_q  <= 1'b0;
            pcm_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          good_q  <= '0;
          lock_q  <= 1'b0;
          pcm_q   <= '0;
        end
      endcase
    end
  end

  assign ERR_O = err_q;
`else
  logic unused_mon_cfg;

  always_ff @(posedge MCLK_I) begin
    if (!ARESETN_I) begin
      pcm_q  <= '0;
      lock_q <= 1'b0;
    end else if (cap_edge) begin
      pcm_q  <= PCM_I;
      lock_q <= 1'b1;
    end
  end

  assign ERR_O          = 1'b0;
  assign unused_mon_cfg = ((MCLK_PER_FS + TOL + LOCK_FRAMES) != 0);
`endif

  assign WCLK_O  = prev_q;
  assign PCM_O   = pcm_q;
  assign VALID_O = valid_q;
  assign LOCK_O  = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_pcm_mclk_sync_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcm_mclk_sync_mc
//  Description : Scoreboard bench for pcm_mclk_sync_mc with a frame-level
//                reference model; follows PCM_MCLK_SYNC_MON_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcm_mclk_sync_mc;

  localparam int DW  = 32;
  localparam int CH  = 2;
  localparam int SS  = 2;
  localparam int PER = 256;
  localparam int TOL = 2;
  localparam int LF  = 4;
`ifdef PCM_MCLK_SYNC_MON_EN
  localparam bit MON = 1'b1;
  localparam int CAP = 0;
`else
  localparam bit MON = 1'b0;
  localparam int CAP = 1;
`endif
  localparam int LO = PER - TOL;
  localparam int HI = PER + TOL;
  localparam int PW = CH * DW;
  localparam logic CL = (CAP == 0);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wclk = 1'b1;
  logic [PW-1:0] pcm_i = '0;
  logic          wclk_o;
  logic [PW-1:0] pcm_o;
  logic          valid_o;
  logic          lock_o;
  logic          err_o;

  always #5 clk = ~clk;

  pcm_mclk_sync_mc #(
    .DATA_WIDTH   (DW),
    .CH_NUM       (CH),
    .SYNC_STAGES  (SS),
    .CAPTURE_EDGE (CAP),
    .MCLK_PER_FS  (PER),
    .TOL          (TOL),
    .LOCK_FRAMES  (LF)
  ) dut (
    .MCLK_I    (clk),
    .ARESETN_I (rstn),
    .WCLK_I    (wclk),
    .PCM_I     (pcm_i),
    .WCLK_O    (wclk_o),
    .PCM_O     (pcm_o),
    .VALID_O   (valid_o),
    .LOCK_O    (lock_o),
    .ERR_O     (err_o)
  );

  typedef struct {
    int            cyc;
    logic [PW-1:0] pcm;
    logic          lock;
  } exp_t;

  exp_t exp_q[$];
  int   err_exp[$];
  int   err_act[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [SS:0] hist = '0;
  bit   mon_en = 1'b0;
  exp_t mon_e;

  // Model state: 0 idle, 1 acquiring, 2 locked
  int            m_st = 0;
  int            m_gc = 0;
  int            m_last = 0;
  logic          m_lock = 1'b0;
  logic [PW-1:0] m_pcm = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Delay line of sampled WCLK_I values; reset clears it like the DUT chain.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) hist <= '0;
    else       hist <= {hist[SS-1:0], wclk};
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("wclk_o_lag", {63'd0, wclk_o}, {63'd0, hist[SS]});
      if (err_o) err_act.push_back(cyc);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL valid_unexpected: VALID_O=1 at cycle %0d, required no pulse", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("pcm_o", pcm_o, mon_e.pcm);
          check("lock_o_at_valid", {63'd0, lock_o}, {63'd0, mon_e.lock});
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL valid_missing: no VALID_O at cycle %0d, required one", mon_e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_edge(input int now, input logic [PW-1:0] pcm);
    int  p;
    bit  good;
    exp_t e;
    p = now - m_last;
    if (MON) begin
      if (m_st != 0 && p > HI + 1) begin
        err_exp.push_back(m_last + HI + 4);
        m_st = 0;
        m_gc = 0;
      end
      good = (p >= LO) && (p <= HI);
      if (m_st == 0) begin
        m_st = 1;
        m_gc = 0;
      end else if (!good) begin
        m_st = 1;
        m_gc = 0;
        err_exp.push_back(now + 3);
      end else if (m_st == 1) begin
        m_gc++;
        if (m_gc == LF) m_st = 2;
      end
      m_lock = (m_st == 2);
      m_pcm  = m_lock ? pcm : '0;
    end else begin
      m_lock = 1'b1;
      m_pcm  = pcm;
    end
    m_last = now;
    e.cyc  = now + 3;
    e.pcm  = m_pcm;
    e.lock = m_lock;
    exp_q.push_back(e);
  endtask

  task automatic model_stopped(input int now);
    if (MON && m_st != 0 && now - m_last >= HI + 4) begin
      err_exp.push_back(m_last + HI + 4);
      m_st   = 0;
      m_gc   = 0;
      m_lock = 1'b0;
      m_pcm  = '0;
    end
  endtask

  task automatic prepare();
    if (wclk == CL) begin
      wclk = ~CL;
      wait_cyc(100);
    end
  endtask

  task automatic frame(input int p, input logic [PW-1:0] next_pcm);
    wclk = CL;
    model_edge(cyc, pcm_i);
    wait_cyc(p / 2);
    wclk  = ~CL;
    pcm_i = next_pcm;
    wait_cyc(p - p / 2);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wclk_o"}, {63'd0, wclk_o}, 64'd0);
    check({tag, "_pcm_o"}, pcm_o, '0);
    check({tag, "_valid_o"}, {63'd0, valid_o}, 64'd0);
    check({tag, "_lock_o"}, {63'd0, lock_o}, 64'd0);
    check({tag, "_err_o"}, {63'd0, err_o}, 64'd0);
  endtask

  function automatic logic [PW-1:0] rnd_pcm();
    return {$urandom, $urandom};
  endfunction

  initial begin
    // Reset with WCLK_I held high through release.
    wait_cyc(2);
    mon_en = 1'b1;
    wait_cyc(1);
    check_idle_outputs("reset");
    rstn = 1'b1;
    wait_cyc(30);
    prepare();
    pcm_i = {32'hFFFF_EDCB, 32'h0000_1234};

    for (int i = 0; i < 6; i++) frame(PER, {32'hFFFF_EDCB, 32'h0000_1234});
    check("lock_steady", {63'd0, lock_o}, {63'd0, m_lock});

    for (int i = 0; i < 4; i++) frame($urandom_range(LO, HI), rnd_pcm());
    frame(260, rnd_pcm());
    for (int i = 0; i < 6; i++) frame($urandom_range(LO, HI), rnd_pcm());
    for (int i = 0; i < 6; i++) frame((i % 2) ? HI : LO, rnd_pcm());
    check("lock_alternating", {63'd0, lock_o}, {63'd0, m_lock});

    for (int i = 0; i < 12; i++) begin
      int r;
      int p;
      r = $urandom_range(0, 9);
      p = (r < 7) ? $urandom_range(LO, HI) : (r == 7) ? LO - 1 : (r == 8) ? HI + 1 : HI + 4;
      frame(p, rnd_pcm());
    end
    for (int i = 0; i < 6; i++) frame(PER, rnd_pcm());

    // Word clock stops.
    wait_cyc(400);
    model_stopped(cyc);
    check("lock_after_stop", {63'd0, lock_o}, {63'd0, m_lock});
    check("pcm_after_stop", pcm_o, m_pcm);

    prepare();
    for (int i = 0; i < 6; i++) frame(PER, rnd_pcm());

    // Reset in the middle of a frame.
    wclk = CL;
    model_edge(cyc, pcm_i);
    wait_cyc(PER / 2);
    wclk = ~CL;
    wait_cyc(20);
    rstn = 1'b0;
    wait_cyc(3);
    m_st   = 0;
    m_gc   = 0;
    m_lock = 1'b0;
    m_pcm  = '0;
    check_idle_outputs("midreset");
    rstn = 1'b1;
    wait_cyc(30);
    prepare();
    for (int i = 0; i < 6; i++) frame(PER, rnd_pcm());
    wait_cyc(10);

    check("err_count", 64'(err_act.size()), 64'(err_exp.size()));
    for (int i = 0; i < err_exp.size() && i < err_act.size(); i++)
      check("err_cycle", 64'(err_act[i]), 64'(err_exp[i]));
    check("pending_valid", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
